// File: rtl/delay_line_pkg.sv
// Shared state encoding and default widths for the delay line controller.
package delay_line_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

endpackage

// File: rtl/delay_line_ctrl_wrap_counter.sv
// Free-running up-counter with synchronous clear; wraps naturally at 2**WIDTH.
module wrap_counter
  import delay_line_pkg::*;
#(
  parameter int WIDTH = ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count register: clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc) begin
      count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/delay_line_ctrl.sv
// Circular-buffer sequencer producing a constant-delay sample stream from a dual-port RAM.
// Optional macro DELAY_LINE_CTRL_MUTE_EN: FILL accepts emit zero-valued output samples.
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W,
  parameter int DATA_WIDTH    = DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ADDRESS_WIDTH-1:0] delay,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     ram_wr_en,
  output logic                     ram_rd_en,
  output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
  output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     running
);

  localparam logic [ADDRESS_WIDTH-1:0] ZERO_A = {ADDRESS_WIDTH{1'b0}};
  localparam logic [ADDRESS_WIDTH-1:0] ONE_A  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_r;
  logic [ADDRESS_WIDTH-1:0] delay_q_r;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_s;
  logic [ADDRESS_WIDTH-1:0] fill_cnt_s;
  logic                     accept_s;
  logic                     rd_req_s;
  logic                     ptr_clr_s;
  logic                     fill_inc_s;
  logic                     fill_done_s;
  logic                     out_valid_next_s;
  logic                     out_valid_r;

  assign in_ready    = (state_r != IDLE);
  assign running     = (state_r == RUN);
  assign accept_s    = in_valid & in_ready;
  assign rd_req_s    = accept_s & (state_r == RUN);
  assign ptr_clr_s   = (state_r == IDLE) | ~en;
  assign fill_inc_s  = accept_s & (state_r == FILL);
  assign fill_done_s = fill_inc_s & ((fill_cnt_s + ONE_A) == delay_q_r);

  wrap_counter #(.WIDTH(ADDRESS_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr   (ptr_clr_s),
    .inc   (accept_s),
    .count (wr_ptr_s)
  );

  wrap_counter #(.WIDTH(ADDRESS_WIDTH)) u_fill_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (ptr_clr_s),
    .inc   (fill_inc_s),
    .count (fill_cnt_s)
  );

  // Read trails the write by delay_q; delay_q >= 1 keeps the two addresses distinct.
  assign ram_wr_en   = accept_s;
  assign ram_rd_en   = rd_req_s;
  assign ram_wr_addr = wr_ptr_s;
  assign ram_rd_addr = wr_ptr_s - delay_q_r;
  assign ram_din     = in_data;

`ifdef DELAY_LINE_CTRL_MUTE_EN
  logic mute_r;

  // Marks an output slot that came from a FILL accept so it reads as silence.
  always_ff @(posedge clk) begin
    if (rst) begin
      mute_r <= 1'b0;
    end else begin
      mute_r <= fill_inc_s;
    end
  end

  assign out_valid_next_s = accept_s;
  assign out_data         = mute_r ? {DATA_WIDTH{1'b0}} : ram_dout;
`else
  assign out_valid_next_s = rd_req_s;
  assign out_data         = ram_dout;
`endif

  // Control FSM, latched delay and the output strobe aligned with RAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      delay_q_r   <= ZERO_A;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_next_s;
      if (!en) begin
        state_r   <= IDLE;
        delay_q_r <= ZERO_A;
      end else begin
        case (state_r)
          IDLE: begin
            state_r   <= FILL;
            delay_q_r <= (delay == ZERO_A) ? ONE_A : delay;
          end
          FILL: begin
            state_r   <= fill_done_s ? RUN : FILL;
            delay_q_r <= delay_q_r;
          end
          RUN: begin
            state_r   <= RUN;
            delay_q_r <= delay_q_r;
          end
          default: begin
            state_r   <= IDLE;
            delay_q_r <= ZERO_A;
          end
        endcase
      end
    end
  end

  assign out_valid = out_valid_r;

endmodule
